// File: rtl/width_gearbox.sv
// Streaming width converter: repacks IN_W-bit beats into OUT_W-bit words, MSB-first,
// with valid/ready on both sides and a zero-padded, flagged final word per frame.
module width_gearbox #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready
);

   localparam int unsigned BUF_W = IN_W + OUT_W;
   localparam int unsigned CNT_W = $clog2(BUF_W + 1);

   typedef enum logic {
      RUN,
      DRAIN
   } state_e;

   logic [BUF_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;

   logic             accept;
   logic             reg_free;
   logic             frame_end;
   logic             emit_full;
   logic             emit_pad;
   logic [BUF_W-1:0] in_ext;
   logic [BUF_W-1:0] comb_buf;
   logic [CNT_W-1:0] tot;

   // Input is only taken when the combined buffer is guaranteed to fit.
   assign in_ready  = (state_q == RUN) && (cnt_q <= CNT_W'(OUT_W));
   assign accept    = in_valid && in_ready;
   assign reg_free  = !out_valid_q || out_ready;

   // New beat lands directly below the cnt valid bits; bits below cnt are always zero.
   assign in_ext    = {in_data, {OUT_W{1'b0}}} >> cnt_q;
   assign comb_buf  = accept ? (acc_q | in_ext) : acc_q;
   assign tot       = cnt_q + (accept ? CNT_W'(IN_W) : CNT_W'(0));

   assign frame_end = (state_q == DRAIN) || (accept && in_last);
   assign emit_full = reg_free && (tot >= CNT_W'(OUT_W));
   assign emit_pad  = reg_free && !emit_full && (state_q == DRAIN) && (cnt_q != '0);

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (accept) begin
         acc_d = comb_buf;
         cnt_d = tot;
         if (in_last) begin
            state_d = DRAIN;
         end
      end

      if (emit_full) begin
         out_valid_d = 1'b1;
         out_data_d  = comb_buf[BUF_W-1 -: OUT_W];
         out_last_d  = frame_end && (tot == CNT_W'(OUT_W));
         acc_d       = comb_buf << OUT_W;
         cnt_d       = tot - CNT_W'(OUT_W);
         if (frame_end && (tot == CNT_W'(OUT_W))) begin
            state_d = RUN;
         end
      end else if (emit_pad) begin
         // Leftover bits are already left-justified with zeros below them.
         out_valid_d = 1'b1;
         out_data_d  = acc_q[BUF_W-1 -: OUT_W];
         out_last_d  = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
         state_d     = RUN;
      end else if (reg_free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         state_q     <= RUN;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule
